// File: rtl/frame_strobe_gen_pkg.sv
// ---------------------------------------------------------------------------
// frame_cfg_pkg : shared types, command field layout and helpers for frame_strobe_gen
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package frame_cfg_pkg;

  typedef enum logic [1:0] {
    ST_UNSYNC     = 2'd0,
    ST_SYNC       = 2'd1,
    ST_STROBE     = 2'd2,
    ST_SETUP_HOLD = 2'd3
  } state_t;

  localparam int c_COL_MSB   = 31;
  localparam int c_COL_LSB   = 27;
  localparam int c_FRAME_MSB = 26;
  localparam int c_FRAME_LSB = 20;

  localparam logic [31:0] c_SYNC_WORD_DEFAULT   = 32'hFAB0_FAB1;
  localparam logic [31:0] c_DESYNC_WORD_DEFAULT = 32'hFAB0_FAB0;

  // One bit of a one-hot frame vector: true when the frame index selects position pos.
  function automatic logic frame_hit(input logic [6:0] frame, input int unsigned pos);
    return {25'd0, frame} == pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_strobe_gen_if.sv
// ---------------------------------------------------------------------------
// frame_strobe_gen_if : command word input and frame-strobe output bundle
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface frame_strobe_gen_if #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5
);
  logic [31:0]                 WriteData;
  logic                        WriteStrobe;
  logic                        Ready;
  logic [FrameSelectWidth-1:0] FrameSelect;
  logic [MaxFramesPerCol-1:0]  FrameStrobe_O;
  logic                        FrameStrobe;
  logic                        Synced;
  logic                        AddrError;

  modport master (
    output WriteData, WriteStrobe,
    input  Ready, FrameSelect, FrameStrobe_O, FrameStrobe, Synced, AddrError
  );

  modport slave (
    input  WriteData, WriteStrobe,
    output Ready, FrameSelect, FrameStrobe_O, FrameStrobe, Synced, AddrError
  );
endinterface

`default_nettype wire

// File: rtl/frame_strobe_gen_cmd_decode.sv
// ---------------------------------------------------------------------------
// frame_cmd_decode : combinational field extraction and address range check
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module frame_cmd_decode
  import frame_cfg_pkg::*;
#(
  parameter int          MaxFramesPerCol  = 20,
  parameter int          FrameSelectWidth = 5,
  parameter int          NumCols          = 14,
  parameter logic [31:0] SyncWord         = c_SYNC_WORD_DEFAULT,
  parameter logic [31:0] DesyncWord       = c_DESYNC_WORD_DEFAULT
) (
  input  wire logic [31:0]                 i_word,
  output logic                             o_is_sync,
  output logic                             o_is_desync,
  output logic                             o_valid,
  output logic                             o_error,
  output logic [FrameSelectWidth-1:0]      o_column,
  output logic [MaxFramesPerCol-1:0]       o_onehot
);

  logic [4:0] w_col_field;
  logic [6:0] w_frame_field;

  assign w_col_field   = i_word[c_COL_MSB:c_COL_LSB];
  assign w_frame_field = i_word[c_FRAME_MSB:c_FRAME_LSB];

  assign o_is_sync   = (i_word == SyncWord);
  assign o_is_desync = (i_word == DesyncWord);

  // Range check uses the full field width, so no index ever wraps into range.
  assign o_valid = ({27'd0, w_col_field} < NumCols) &&
                   ({25'd0, w_frame_field} < MaxFramesPerCol);
  assign o_error = ~o_valid;

  generate
    if (FrameSelectWidth < 5) begin : g_col_trunc
      assign o_column = w_col_field[FrameSelectWidth-1:0];
    end else if (FrameSelectWidth == 5) begin : g_col_same
      assign o_column = w_col_field;
    end else begin : g_col_ext
      assign o_column = {{(FrameSelectWidth-5){1'b0}}, w_col_field};
    end
  endgenerate

  generate
    for (genvar i = 0; i < MaxFramesPerCol; i++) begin : g_onehot
      assign o_onehot[i] = frame_hit(w_frame_field, i);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/frame_strobe_gen.sv
// ---------------------------------------------------------------------------
// frame_strobe_gen : sync-framed command decoder emitting one frame strobe per valid word
// Optional macro FRAME_STROBE_GUARD_EN adds setup/hold guard cycles. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_strobe_gen
  import frame_cfg_pkg::*;
#(
  parameter int          MaxFramesPerCol  = 20,
  parameter int          FrameSelectWidth = 5,
  parameter int          NumCols          = 14,
  parameter logic [31:0] SyncWord         = c_SYNC_WORD_DEFAULT,
  parameter logic [31:0] DesyncWord       = c_DESYNC_WORD_DEFAULT
) (
  input wire logic          CLK,
  input wire logic          Reset,
  frame_strobe_gen_if.slave bus
);

  state_t                      r_state;
  logic                        r_ready;
  logic [FrameSelectWidth-1:0] r_fsel;
  logic [MaxFramesPerCol-1:0]  r_fso;
  logic                        r_strobe;
  logic                        r_synced;
  logic                        r_err;
`ifdef FRAME_STROBE_GUARD_EN
  logic                        r_hold_phase;
`endif

  logic                        w_accept;
  logic                        w_is_sync;
  logic                        w_is_desync;
  logic                        w_valid;
  logic                        w_error;
  logic [FrameSelectWidth-1:0] w_column;
  logic [MaxFramesPerCol-1:0]  w_onehot;

  frame_cmd_decode #(
    .MaxFramesPerCol  (MaxFramesPerCol),
    .FrameSelectWidth (FrameSelectWidth),
    .NumCols          (NumCols),
    .SyncWord         (SyncWord),
    .DesyncWord       (DesyncWord)
  ) u_decode (
    .i_word      (bus.WriteData),
    .o_is_sync   (w_is_sync),
    .o_is_desync (w_is_desync),
    .o_valid     (w_valid),
    .o_error     (w_error),
    .o_column    (w_column),
    .o_onehot    (w_onehot)
  );

  assign w_accept = bus.WriteStrobe & r_ready;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= ST_UNSYNC;
      r_ready      <= 1'b1;
      r_fsel       <= '0;
      r_fso        <= '0;
      r_strobe     <= 1'b0;
      r_synced     <= 1'b0;
      r_err        <= 1'b0;
`ifdef FRAME_STROBE_GUARD_EN
      r_hold_phase <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_UNSYNC: begin
          if (w_accept && w_is_sync) begin
            r_state  <= ST_SYNC;
            r_synced <= 1'b1;
            r_err    <= 1'b0;
          end
        end

        ST_SYNC: begin
          if (w_accept) begin
            if (w_is_desync) begin
              r_state  <= ST_UNSYNC;
              r_synced <= 1'b0;
            end else if (w_is_sync) begin
              r_err <= 1'b0;
            end else if (w_valid) begin
              r_fsel  <= w_column;
              r_fso   <= w_onehot;
              r_ready <= 1'b0;
`ifdef FRAME_STROBE_GUARD_EN
              // Address goes out first; the strobe follows in the next cycle.
              r_state      <= ST_SETUP_HOLD;
              r_hold_phase <= 1'b0;
`else
              r_strobe <= 1'b1;
              r_state  <= ST_STROBE;
`endif
            end else if (w_error) begin
              r_err <= 1'b1;
            end
          end
        end

        ST_STROBE: begin
          r_strobe <= 1'b0;
`ifdef FRAME_STROBE_GUARD_EN
          r_state      <= ST_SETUP_HOLD;
          r_hold_phase <= 1'b1;
`else
          r_fso   <= '0;
          r_ready <= 1'b1;
          r_state <= ST_SYNC;
`endif
        end

`ifdef FRAME_STROBE_GUARD_EN
        ST_SETUP_HOLD: begin
          if (!r_hold_phase) begin
            r_strobe <= 1'b1;
            r_state  <= ST_STROBE;
          end else begin
            r_fso        <= '0;
            r_ready      <= 1'b1;
            r_hold_phase <= 1'b0;
            r_state      <= ST_SYNC;
          end
        end
`endif

        default: r_state <= ST_UNSYNC;
      endcase
    end
  end

  assign bus.Ready         = r_ready;
  assign bus.FrameSelect   = r_fsel;
  assign bus.FrameStrobe_O = r_fso;
  assign bus.FrameStrobe   = r_strobe;
  assign bus.Synced        = r_synced;
  assign bus.AddrError     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_frame_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_frame_strobe_gen : directed scoreboard bench for frame_strobe_gen
// Honours FRAME_STROBE_GUARD_EN when defined. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_strobe_gen;

  localparam logic [31:0] c_SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] c_DESYNC = 32'hFAB0_FAB0;

  typedef struct packed {
    logic [4:0]  sel;
    logic [19:0] oh;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total   = 0;
  int   bad     = 0;
  int   n_str   = 0;
  logic prev_fs = 1'b0;
  exp_t q[$];

  frame_strobe_gen_if #(.MaxFramesPerCol(20), .FrameSelectWidth(5)) bus ();

  frame_strobe_gen #(
    .MaxFramesPerCol  (20),
    .FrameSelectWidth (5),
    .NumCols          (14),
    .SyncWord         (c_SYNC),
    .DesyncWord       (c_DESYNC)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bus.WriteData   = w;
    bus.WriteStrobe = 1'b1;
    tick();
    bus.WriteStrobe = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.Ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("ready_timeout", {31'd0, bus.Ready}, 32'd1);
  endtask

  // Scoreboard side: every strobe pops the oldest expected transaction.
  always @(negedge clk) begin
    if (bus.FrameStrobe === 1'b1) begin
      n_str++;
      chk("strobe_width", {31'd0, prev_fs}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_strobe", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_sel", {27'd0, bus.FrameSelect}, {27'd0, e.sel});
        chk("strobe_oh", {12'd0, bus.FrameStrobe_O}, {12'd0, e.oh});
      end
    end
    prev_fs = bus.FrameStrobe;
  end

  initial begin
    int s0;
    rst             = 1'b1;
    bus.WriteData   = '0;
    bus.WriteStrobe = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_ready",  {31'd0, bus.Ready},         32'd1);
    chk("rst_fsel",   {27'd0, bus.FrameSelect},   32'd0);
    chk("rst_fso",    {12'd0, bus.FrameStrobe_O}, 32'd0);
    chk("rst_fs",     {31'd0, bus.FrameStrobe},   32'd0);
    chk("rst_synced", {31'd0, bus.Synced},        32'd0);
    chk("rst_err",    {31'd0, bus.AddrError},     32'd0);

    // Command while unsynced is ignored.
    send(32'h0810_0000);
    repeat (3) tick();
    chk("unsync_nostrobe", 32'(n_str), 32'd0);
    chk("unsync_synced",   {31'd0, bus.Synced},    32'd0);
    chk("unsync_err",      {31'd0, bus.AddrError}, 32'd0);

    send(c_SYNC);
    chk("sync_synced", {31'd0, bus.Synced}, 32'd1);

    // Column 3, frame 5.
    q.push_back('{sel: 5'd3, oh: 20'h00020});
    send(32'h1850_0000);
`ifdef FRAME_STROBE_GUARD_EN
    chk("setup_fs",    {31'd0, bus.FrameStrobe},   32'd0);
    chk("setup_ready", {31'd0, bus.Ready},         32'd0);
    chk("setup_fsel",  {27'd0, bus.FrameSelect},   32'd3);
    chk("setup_fso",   {12'd0, bus.FrameStrobe_O}, 32'h20);
    tick();
    chk("c3_fs",       {31'd0, bus.FrameStrobe},   32'd1);
    tick();
    chk("hold_fs",     {31'd0, bus.FrameStrobe},   32'd0);
    chk("hold_fso",    {12'd0, bus.FrameStrobe_O}, 32'h20);
    chk("hold_ready",  {31'd0, bus.Ready},         32'd0);
    tick();
`else
    chk("c3_fs",    {31'd0, bus.FrameStrobe},   32'd1);
    chk("c3_ready", {31'd0, bus.Ready},         32'd0);
    chk("c3_fsel",  {27'd0, bus.FrameSelect},   32'd3);
    chk("c3_fso",   {12'd0, bus.FrameStrobe_O}, 32'h20);
    tick();
`endif
    chk("c3_ready_back", {31'd0, bus.Ready},         32'd1);
    chk("c3_fs_low",     {31'd0, bus.FrameStrobe},   32'd0);
    chk("c3_fso_zero",   {12'd0, bus.FrameStrobe_O}, 32'd0);
    chk("c3_fsel_kept",  {27'd0, bus.FrameSelect},   32'd3);
    chk("c3_count",      32'(n_str),                 32'd1);

    // Column 14 is out of range.
    send(32'h7000_0000);
    chk("col14_err",   {31'd0, bus.AddrError},   32'd1);
    chk("col14_fs",    {31'd0, bus.FrameStrobe}, 32'd0);
    chk("col14_ready", {31'd0, bus.Ready},       32'd1);
    repeat (3) tick();
    chk("col14_count", 32'(n_str), 32'd1);
    send(c_SYNC);
    chk("resync_err",    {31'd0, bus.AddrError}, 32'd0);
    chk("resync_synced", {31'd0, bus.Synced},    32'd1);

    // Frame 20 is out of range, frame 19 is the last valid one.
    send(32'h0140_0000);
    chk("f20_err", {31'd0, bus.AddrError}, 32'd1);
    q.push_back('{sel: 5'd0, oh: 20'h80000});
    send(32'h0130_0000);
    wait_idle();
    chk("f19_err_sticky", {31'd0, bus.AddrError}, 32'd1);
    chk("f19_count",      32'(n_str),             32'd2);

    // Back-to-back: second word lands while Ready is low and is dropped.
    s0 = n_str;
    q.push_back('{sel: 5'd5, oh: 20'h00004});
    bus.WriteData   = 32'h2820_0000;
    bus.WriteStrobe = 1'b1;
    tick();
    chk("b2b_ready_low", {31'd0, bus.Ready}, 32'd0);
    bus.WriteData = 32'h3010_0000;
    tick();
    bus.WriteStrobe = 1'b0;
    wait_idle();
    repeat (4) tick();
    chk("b2b_one_strobe", 32'(n_str - s0), 32'd1);
    chk("b2b_fsel",       {27'd0, bus.FrameSelect}, 32'd5);

    // Reset during the strobe cycle.
    q.push_back('{sel: 5'd1, oh: 20'h00001});
    send(32'h0800_0000);
`ifdef FRAME_STROBE_GUARD_EN
    tick();
`endif
    chk("pre_rst_fs", {31'd0, bus.FrameStrobe}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abort_fs",     {31'd0, bus.FrameStrobe},   32'd0);
    chk("rst_abort_fso",    {12'd0, bus.FrameStrobe_O}, 32'd0);
    chk("rst_abort_synced", {31'd0, bus.Synced},        32'd0);
    chk("rst_abort_ready",  {31'd0, bus.Ready},         32'd1);
    chk("rst_abort_fsel",   {27'd0, bus.FrameSelect},   32'd0);

    // Desync path: sync, desync, then a valid-looking command must not strobe.
    send(c_SYNC);
    send(c_DESYNC);
    chk("desync_synced", {31'd0, bus.Synced}, 32'd0);
    s0 = n_str;
    send(32'h1850_0000);
    repeat (4) tick();
    chk("desync_nostrobe", 32'(n_str - s0), 32'd0);

    chk("sb_empty",    32'(q.size()), 32'd0);
    chk("total_strobes", 32'(n_str),  32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
